// File: rtl/adder_arbiter_pkg.sv
// Shared types for the adder arbiter: FSM state encoding and default watchdog limit.
package adder_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   localparam int DEFAULT_TIMEOUT_CYC = 16;

endpackage

// File: rtl/adder_arbiter_if.sv
// Bundle of requester, response and adder-side signals around the adder arbiter.
interface adder_arbiter_if #(
   parameter int DATA_BIT = 64,
   parameter int NUM_REQ  = 4
);

   // Each channel transfers on a clock edge where its valid and ready are both high;
   // a requester keeps its operands stable while req_valid is high and not yet accepted.
   logic [NUM_REQ-1:0]          req_valid;
   logic [NUM_REQ-1:0]          req_ready;
   logic [NUM_REQ*DATA_BIT-1:0] req_summand;
   logic [NUM_REQ*DATA_BIT-1:0] req_addend;
   logic [NUM_REQ-1:0]          rsp_valid;
   logic [NUM_REQ-1:0]          rsp_ready;
   logic [DATA_BIT-1:0]         rsp_result;
   logic                        rsp_over_flow;
   logic                        rsp_error;
   logic                        add_enable;
   logic [DATA_BIT-1:0]         add_summand;
   logic [DATA_BIT-1:0]         add_addend;
   logic [DATA_BIT-1:0]         add_result;
   logic                        add_over_flow;
   logic                        add_valid;

   modport master (
      input  req_valid, req_summand, req_addend, rsp_ready,
      input  add_result, add_over_flow, add_valid,
      output req_ready, rsp_valid, rsp_result, rsp_over_flow, rsp_error,
      output add_enable, add_summand, add_addend
   );

   modport slave (
      output req_valid, req_summand, req_addend, rsp_ready,
      output add_result, add_over_flow, add_valid,
      input  req_ready, rsp_valid, rsp_result, rsp_over_flow, rsp_error,
      input  add_enable, add_summand, add_addend
   );

endinterface

// File: rtl/adder_arbiter_rr_picker.sv
// Combinational rotate-priority search: first asserted request after last_grant, with wrap.
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IDX_W-1:0]   last_grant,
   output logic               grant_valid,
   output logic [IDX_W-1:0]   grant_idx
);

   int cand;

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      // Distance 1 is checked first so the previous winner has lowest priority.
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = (int'(last_grant) + i) % NUM_REQ;
         if (!grant_valid && req_valid[IDX_W'(cand)]) begin
            grant_valid = 1'b1;
            grant_idx   = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining ADDER_ARB_TIMEOUT_EN.
module adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter int DATA_BIT    = 64,
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
   input  logic             clk,
   input  logic             reset_n,
   adder_arbiter_if.master  bus,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   localparam int IDX_W = $clog2(NUM_REQ);

   localparam logic [1:0] S_IDLE  = 2'(IDLE);
   localparam logic [1:0] S_ISSUE = 2'(ISSUE);
   localparam logic [1:0] S_WAIT  = 2'(WAIT);
   localparam logic [1:0] S_RESP  = 2'(RESP);

   logic [1:0]          state;
   logic [IDX_W-1:0]    last_grant;
   logic [IDX_W-1:0]    win_idx;
   logic [DATA_BIT-1:0] op_summand;
   logic [DATA_BIT-1:0] op_addend;
   logic [DATA_BIT-1:0] res_q;
   logic                ovf_q;
   logic                grant_valid;
   logic [IDX_W-1:0]    grant_idx;

`ifdef ADDER_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] wait_cnt;
   logic             err_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYC > 0);
`endif

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req_valid   (bus.req_valid),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         last_grant <= IDX_W'(NUM_REQ - 1);
         win_idx    <= '0;
         op_summand <= '0;
         op_addend  <= '0;
         res_q      <= '0;
         ovf_q      <= 1'b0;
`ifdef ADDER_ARB_TIMEOUT_EN
         wait_cnt   <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_valid) begin
                  win_idx    <= grant_idx;
                  op_summand <= bus.req_summand[grant_idx*DATA_BIT +: DATA_BIT];
                  op_addend  <= bus.req_addend[grant_idx*DATA_BIT +: DATA_BIT];
                  state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // A zero-latency adder answers in the same cycle as the enable.
               if (bus.add_valid) begin
                  res_q <= bus.add_result;
                  ovf_q <= bus.add_over_flow;
`ifdef ADDER_ARB_TIMEOUT_EN
                  err_q <= 1'b0;
`endif
                  state <= S_RESP;
               end else begin
`ifdef ADDER_ARB_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.add_valid) begin
                  res_q <= bus.add_result;
                  ovf_q <= bus.add_over_flow;
`ifdef ADDER_ARB_TIMEOUT_EN
                  err_q <= 1'b0;
`endif
                  state <= S_RESP;
               end
`ifdef ADDER_ARB_TIMEOUT_EN
               else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  res_q <= '0;
                  ovf_q <= 1'b0;
                  err_q <= 1'b1;
                  state <= S_RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            S_RESP: begin
               if (bus.rsp_ready[win_idx]) begin
                  last_grant <= win_idx;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.req_ready = '0;
      if (state == S_IDLE && grant_valid) begin
         bus.req_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      bus.rsp_valid = '0;
      if (state == S_RESP) begin
         bus.rsp_valid[win_idx] = 1'b1;
      end
   end

   assign bus.rsp_result    = res_q;
   assign bus.rsp_over_flow = ovf_q;
`ifdef ADDER_ARB_TIMEOUT_EN
   assign bus.rsp_error     = err_q;
`else
   assign bus.rsp_error     = 1'b0;
`endif
   assign bus.add_enable    = (state == S_ISSUE);
   assign bus.add_summand   = op_summand;
   assign bus.add_addend    = op_addend;
   assign busy              = (state != S_IDLE);
   assign dbg_state         = state;

endmodule
